// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic array edge feeder.
// Imported by the feeder top and its per-lane skew multiplexer.
package systolic_pkg;

    localparam int N_DEF      = 4;
    localparam int DW_DEF     = 8;
    localparam int FLOAT_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

    // Number of skewed steps needed to push a full NxN band through the edge.
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_mux.sv
// One edge lane: picks element (t - LANE) of the lane's operand vector,
// or float zero when that index falls outside the band.
module skew_mux
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int TW   = 5,
    parameter int LANE = 0
) (
    input  logic [N*DW-1:0] vec,
    input  logic [TW-1:0]   t,
    output logic [DW-1:0]   elem
);

    // Diagonal select: element k is on this lane at step LANE + k.
    always_comb begin
        elem = DW'(FLOAT_ZERO);
        for (int k = 0; k < N; k++) begin
            elem = (int'(t) == LANE + k) ? vec[k*DW +: DW] : elem;
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// West/north edge driver for the NxN systolic array: stores A and B, streams
// them out with diagonal skew, drains with zeros, then pulses done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DW        = DW_DEF,
    parameter int DRAIN_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    output logic [N*DW-1:0]      a_edge,
    output logic [N*DW-1:0]      b_edge,
    output logic                 busy,
    output logic                 done
);

    localparam int FEED_LEN = feed_len(N);
    localparam int TW       = $clog2(FEED_LEN + DRAIN_CYC);

    feed_state_e     state_r, state_nxt_s;
    logic [TW-1:0]   step_r, step_nxt_s;

    logic [DW-1:0]   a_mem_r [N][N];
    logic [DW-1:0]   b_mem_r [N][N];
    logic [DW-1:0]   a_mem_s [N][N];
    logic [DW-1:0]   b_mem_s [N][N];
    logic [N*DW-1:0] a_row_s [N];
    logic [N*DW-1:0] b_col_s [N];
    logic [N*DW-1:0] a_lane_s, b_lane_s;
    logic [N*DW-1:0] a_nxt_s, b_nxt_s;
    logic            busy_nxt_s, done_nxt_s;
    logic            wr_ok_s;

    assign wr_ok_s = wr_en && (state_r == ST_IDLE);

    // Storage view after this cycle's write; feeding from it lets step 0
    // pick up a write issued in the same cycle as start.
    always_comb begin
        a_mem_s = a_mem_r;
        b_mem_s = b_mem_r;
        if (wr_ok_s && (wr_sel == 1'b0)) begin
            a_mem_s[wr_row][wr_col] = wr_data;
        end else if (wr_ok_s && (wr_sel == 1'b1)) begin
            b_mem_s[wr_row][wr_col] = wr_data;
        end else begin
            a_mem_s = a_mem_r;
        end
    end

    // Operand storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        a_mem_r <= a_mem_s;
        b_mem_r <= b_mem_s;
    end

    // Pack A rows and B columns as per-lane vectors indexed by skew position.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_row_s[i] = '0;
            b_col_s[i] = '0;
            for (int j = 0; j < N; j++) begin
                a_row_s[i][j*DW +: DW] = a_mem_s[i][j];
                b_col_s[i][j*DW +: DW] = b_mem_s[j][i];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        skew_mux #(.N(N), .DW(DW), .TW(TW), .LANE(k)) u_a_mux (
            .vec  (a_row_s[k]),
            .t    (step_nxt_s),
            .elem (a_lane_s[k*DW +: DW])
        );
        skew_mux #(.N(N), .DW(DW), .TW(TW), .LANE(k)) u_b_mux (
            .vec  (b_col_s[k]),
            .t    (step_nxt_s),
            .elem (b_lane_s[k*DW +: DW])
        );
    end

    // State and step counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            step_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Next state; the step counter restarts on every state change.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        case (state_r)
            ST_IDLE: begin
                step_nxt_s = '0;
                if (start) begin
                    state_nxt_s = ST_FEED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (step_r == TW'(FEED_LEN - 1)) begin
                    state_nxt_s = ST_DRAIN;
                    step_nxt_s  = '0;
                end else begin
                    step_nxt_s  = step_r + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (step_r == TW'(DRAIN_CYC - 1)) begin
                    state_nxt_s = ST_DONE;
                    step_nxt_s  = '0;
                end else begin
                    step_nxt_s  = step_r + TW'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                step_nxt_s  = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                step_nxt_s  = '0;
            end
        endcase
    end

    // Output values for the upcoming state, so the registers track it exactly.
    always_comb begin
        if (state_nxt_s == ST_FEED) begin
            a_nxt_s = a_lane_s;
            b_nxt_s = b_lane_s;
        end else begin
            a_nxt_s = '0;
            b_nxt_s = '0;
        end
        busy_nxt_s = (state_nxt_s == ST_FEED) || (state_nxt_s == ST_DRAIN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Registered edge outputs and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_edge <= '0;
            b_edge <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            a_edge <= a_nxt_s;
            b_edge <= b_nxt_s;
            busy   <= busy_nxt_s;
            done   <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4, DW=8, DRAIN_CYC=8) using a
// matrix-level reference model of the skewed edge streams.
module tb_systolic_skew_feeder;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_row;
    logic [1:0]  wr_col;
    logic [7:0]  wr_data;
    logic        start;
    logic [31:0] a_edge;
    logic [31:0] b_edge;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0]  am [4][4];
    logic [7:0]  bm [4][4];
    logic [31:0] cap_a [0:31];
    logic [31:0] cap_b [0:31];

    systolic_skew_feeder #(.N(4), .DW(8), .DRAIN_CYC(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .start   (start),
        .a_edge  (a_edge),
        .b_edge  (b_edge),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Row i of the west edge carries A[i][t-i] at step t.
    function automatic logic [31:0] exp_a(input int t);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i < 4) r = r | (32'(am[i][t-i]) << (8 * i));
        return r;
    endfunction

    // Column j of the north edge carries B[t-j][j] at step t.
    function automatic logic [31:0] exp_b(input int t);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < 4; j++)
            if (t - j >= 0 && t - j < 4) r = r | (32'(bm[t-j][j]) << (8 * j));
        return r;
    endfunction

    task automatic wr(input logic sel, input int r, input int c, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) bm[r][c] = d; else am[r][c] = d;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wr(1'b0, i, j, 8'(8'h10 + 4 * i + j));
                wr(1'b1, i, j, 8'(8'h40 + 4 * i + j));
            end
    endtask

    task automatic load_random();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wr(1'b0, i, j, 8'($urandom_range(0, 255)));
                wr(1'b1, i, j, 8'($urandom_range(0, 255)));
            end
    endtask

    // Start a feed and check every cycle; abort_at>0 drops reset in that cycle.
    task automatic run_feed(input bit poke, input int abort_at, input bit wr_with_start,
                            input logic [7:0] wdat);
        int busy_cnt = 0;
        int d0 = done_cnt;
        logic [31:0] ea, eb;
        logic ebusy, edone;
        start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = wdat;
            am[0][0] = wdat;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            if (c <= 10) begin
                ea = exp_a(c - 1); eb = exp_b(c - 1); ebusy = 1'b1; edone = 1'b0;
            end else if (c <= 18) begin
                ea = 32'h0; eb = 32'h0; ebusy = 1'b1; edone = 1'b0;
            end else if (c == 19) begin
                ea = 32'h0; eb = 32'h0; ebusy = 1'b0; edone = 1'b1;
            end else begin
                ea = 32'h0; eb = 32'h0; ebusy = 1'b0; edone = 1'b0;
            end
            chk($sformatf("a_edge c%0d", c), a_edge, ea);
            chk($sformatf("b_edge c%0d", c), b_edge, eb);
            chk($sformatf("busy c%0d", c), {31'h0, busy}, {31'h0, ebusy});
            chk($sformatf("done c%0d", c), {31'h0, done}, {31'h0, edone});
            cap_a[c] = a_edge;
            cap_b[c] = b_edge;
            if (busy === 1'b1) busy_cnt++;
            if (poke && c == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hFF;
                start = 1'b1;
            end
            if (abort_at == c) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort a_edge", a_edge, 32'h0);
                chk("abort b_edge", b_edge, 32'h0);
                chk("abort busy/done", {30'h0, busy, done}, 32'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        chk("busy cycles", 32'(busy_cnt), 32'd18);
        chk("done pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
        wr_data = 8'h00; start = 1'b0;

        // Asynchronous reset, asserted mid-cycle before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst a_edge", a_edge, 32'h0);
        chk("rst b_edge", b_edge, 32'h0);
        chk("rst busy/done", {30'h0, busy, done}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("idle outputs", {a_edge[29:0], busy, done} | {2'b0, b_edge[31:2]} , 32'h0);
        end

        // Directed skew pattern.
        load_pattern();
        run_feed(1'b0, 0, 1'b0, 8'h00);
        chk("c1 a_edge", cap_a[1], 32'h00000010);
        chk("c1 b_edge", cap_b[1], 32'h00000040);
        chk("t3 a_edge", cap_a[4], 32'h1C191613);
        chk("t3 b_edge", cap_b[4], 32'h4346494C);
        chk("t6 a_edge", cap_a[7], 32'h1F000000);
        chk("t6 b_edge", cap_b[7], 32'h4F000000);

        // Write and start while busy are both ignored.
        run_feed(1'b1, 0, 1'b0, 8'h00);
        run_feed(1'b0, 0, 1'b0, 8'h00);
        chk("A00 kept after busy write", cap_a[1], 32'h00000010);

        // Reset in the middle of FEED: no done, matrices retained.
        d0 = done_cnt;
        run_feed(1'b0, 4, 1'b0, 8'h00);
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            chk("no done after abort", {31'h0, done}, 32'h0);
        end
        chk("done count after abort", 32'(done_cnt - d0), 32'd0);
        run_feed(1'b0, 0, 1'b0, 8'h00);
        chk("replay t3 a_edge", cap_a[4], 32'h1C191613);

        // Same-cycle write and start uses the new value at step 0.
        run_feed(1'b0, 0, 1'b1, 8'h77);
        chk("same-cycle A00", cap_a[1], 32'h00000077);

        // Randomized matrices against the reference model.
        for (int r = 0; r < 3; r++) begin
            load_random();
            run_feed(1'b0, 0, 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
